// File: rtl/pcileech_eth_rmii_rx.sv
// rtl/pcileech_eth_rmii_rx.sv - RMII receive framer: preamble strip, byte assembly, CRC/length check, frame counters
// Build option: define PCILEECH_ETH_RX_STRIP_FCS_EN to keep the 4 FCS bytes out of the output stream.
module pcileech_eth_rmii_rx #(
   parameter int PARAM_MIN_FRAME = 64,
   parameter int PARAM_MAX_FRAME = 1522
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        eth_crs_dv,
   input  logic [1:0]  eth_rx_data,
   input  logic        eth_rx_err,
   output logic [7:0]  rx_data,
   output logic        rx_valid,
   output logic        rx_sof,
   output logic        rx_eof,
   output logic        rx_err,
   output logic [15:0] cnt_frame_ok,
   output logic [15:0] cnt_frame_bad
);

`ifdef PCILEECH_ETH_RX_STRIP_FCS_EN
   // Four FCS bytes plus the last payload byte, so eof can land on the payload byte.
   localparam int HOLD_DEPTH = 5;
`else
   localparam int HOLD_DEPTH = 1;
`endif

   localparam int                CNT_W       = $clog2(PARAM_MAX_FRAME + 2);
   localparam logic [CNT_W-1:0]  MIN_CNT     = CNT_W'(PARAM_MIN_FRAME);
   localparam logic [CNT_W-1:0]  MAX_CNT     = CNT_W'(PARAM_MAX_FRAME);
   localparam logic [2:0]        HOLD_FULL   = 3'(HOLD_DEPTH);
   // MSB-first register fed LSB-first per byte; good-frame residue in this orientation.
   localparam logic [31:0]       CRC_RESIDUE = 32'hC704DD7B;

   typedef enum logic [1:0] {
      S_IDLE,
      S_PRE,
      S_DATA,
      S_DROP
   } state_t;

   state_t                  state_q;
   logic [1:0]              dibit_cnt_q;
   logic [5:0]              shift_q;
   logic [CNT_W-1:0]        byte_cnt_q;
   logic [31:0]             crc_q;
   logic [8*HOLD_DEPTH-1:0] hold_q;
   logic [2:0]              fill_q;
   logic                    first_q;
   logic                    rxerr_seen_q;
   logic                    crs_low_q;
   logic [7:0]              rx_data_q;
   logic                    rx_valid_q;
   logic                    rx_sof_q;
   logic                    rx_eof_q;
   logic                    rx_err_q;
   logic                    ok_inc_q;
   logic                    bad_inc_q;
   logic [15:0]             cnt_ok_q;
   logic [15:0]             cnt_bad_q;

   logic [5:0]              shift_d;
   logic [7:0]              byte_new;
   logic [31:0]             crc_d;
   logic [8*HOLD_DEPTH-1:0] hold_d;
   logic [7:0]              hold_oldest;
   logic                    hold_full;
   logic                    eoc;
   logic                    frame_err;
   logic [15:0]             cnt_ok_d;
   logic [15:0]             cnt_bad_d;

   // One byte of Ethernet CRC-32, data bits taken LSB first.
   function automatic logic [31:0] crc32_byte(input logic [31:0] c, input logic [7:0] d);
      logic [31:0] r;
      r = c;
      for (int i = 0; i < 8; i++) begin
         if (r[31] ^ d[i]) begin
            r = {r[30:0], 1'b0} ^ 32'h04C11DB7;
         end else begin
            r = {r[30:0], 1'b0};
         end
      end
      return r;
   endfunction

   // Holding register shifts toward the top; the oldest byte sits in the top slot.
   if (HOLD_DEPTH > 1) begin : g_hold_deep
      assign hold_d = {hold_q[8*HOLD_DEPTH-9:0], byte_new};
   end else begin : g_hold_single
      assign hold_d = byte_new;
   end

   // Datapath helpers: byte assembly, CRC step, end-of-carrier and frame verdict.
   always_comb begin
      shift_d     = {eth_rx_data, shift_q[5:2]};
      byte_new    = {eth_rx_data, shift_q};
      crc_d       = crc32_byte(crc_q, byte_new);
      hold_oldest = hold_q[8*HOLD_DEPTH-1 -: 8];
      hold_full   = (fill_q == HOLD_FULL);
      // A single low cycle is the mid-frame CRS_DV toggle; two in a row end the carrier.
      eoc         = ~eth_crs_dv & crs_low_q;
      frame_err   = (crc_q != CRC_RESIDUE) | (byte_cnt_q < MIN_CNT) |
                    rxerr_seen_q | eth_rx_err | (dibit_cnt_q != 2'd0);
   end

   // Saturating next values for the frame counters.
   always_comb begin
      cnt_ok_d  = cnt_ok_q;
      cnt_bad_d = cnt_bad_q;
      if (ok_inc_q && (cnt_ok_q != 16'hFFFF)) begin
         cnt_ok_d = cnt_ok_q + 16'd1;
      end
      if (bad_inc_q && (cnt_bad_q != 16'hFFFF)) begin
         cnt_bad_d = cnt_bad_q + 16'd1;
      end
   end

   // Receive FSM with registered output stream and counter increment pulses.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         dibit_cnt_q  <= 2'd0;
         shift_q      <= 6'd0;
         byte_cnt_q   <= '0;
         crc_q        <= 32'hFFFFFFFF;
         hold_q       <= '0;
         fill_q       <= 3'd0;
         first_q      <= 1'b0;
         rxerr_seen_q <= 1'b0;
         crs_low_q    <= 1'b0;
         rx_data_q    <= 8'd0;
         rx_valid_q   <= 1'b0;
         rx_sof_q     <= 1'b0;
         rx_eof_q     <= 1'b0;
         rx_err_q     <= 1'b0;
         ok_inc_q     <= 1'b0;
         bad_inc_q    <= 1'b0;
      end else begin
         rx_valid_q <= 1'b0;
         rx_sof_q   <= 1'b0;
         rx_eof_q   <= 1'b0;
         rx_err_q   <= 1'b0;
         ok_inc_q   <= 1'b0;
         bad_inc_q  <= 1'b0;
         crs_low_q  <= ~eth_crs_dv;

         case (state_q)
            S_IDLE: begin
               if (eth_crs_dv && (eth_rx_data == 2'b01)) begin
                  state_q <= S_PRE;
               end
            end

            S_PRE: begin
               if (!eth_crs_dv) begin
                  // False carrier: nothing counted.
                  state_q <= S_IDLE;
               end else if (eth_rx_data == 2'b11) begin
                  state_q      <= S_DATA;
                  dibit_cnt_q  <= 2'd0;
                  byte_cnt_q   <= '0;
                  crc_q        <= 32'hFFFFFFFF;
                  fill_q       <= 3'd0;
                  first_q      <= 1'b1;
                  rxerr_seen_q <= 1'b0;
               end else if (eth_rx_data != 2'b01) begin
                  state_q   <= S_DROP;
                  bad_inc_q <= 1'b1;
               end
            end

            S_DATA: begin
               if (eoc) begin
                  state_q <= S_IDLE;
                  if (hold_full) begin
                     rx_data_q  <= hold_oldest;
                     rx_valid_q <= 1'b1;
                     rx_sof_q   <= first_q;
                     rx_eof_q   <= 1'b1;
                     rx_err_q   <= frame_err;
                     first_q    <= 1'b0;
                  end
                  // Frames too short to emit anything are always bad.
                  if (frame_err || !hold_full) begin
                     bad_inc_q <= 1'b1;
                  end else begin
                     ok_inc_q <= 1'b1;
                  end
               end else begin
                  if (eth_rx_err) begin
                     rxerr_seen_q <= 1'b1;
                  end
                  if (eth_crs_dv) begin
                     shift_q     <= shift_d;
                     dibit_cnt_q <= dibit_cnt_q + 2'd1;
                     if (dibit_cnt_q == 2'd3) begin
                        if (byte_cnt_q == MAX_CNT) begin
                           // Oversize: close the frame on the held byte and discard the rest.
                           state_q   <= S_DROP;
                           bad_inc_q <= 1'b1;
                           if (hold_full) begin
                              rx_data_q  <= hold_oldest;
                              rx_valid_q <= 1'b1;
                              rx_sof_q   <= first_q;
                              rx_eof_q   <= 1'b1;
                              rx_err_q   <= 1'b1;
                              first_q    <= 1'b0;
                           end
                        end else begin
                           crc_q      <= crc_d;
                           byte_cnt_q <= byte_cnt_q + 1'b1;
                           hold_q     <= hold_d;
                           if (hold_full) begin
                              rx_data_q  <= hold_oldest;
                              rx_valid_q <= 1'b1;
                              rx_sof_q   <= first_q;
                              first_q    <= 1'b0;
                           end else begin
                              fill_q <= fill_q + 3'd1;
                           end
                        end
                     end
                  end
               end
            end

            S_DROP: begin
               if (eoc) begin
                  state_q <= S_IDLE;
               end
            end

            default: state_q <= S_IDLE;
         endcase
      end
   end

   // Frame counters, one cycle behind the eof that decides them.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_ok_q  <= 16'd0;
         cnt_bad_q <= 16'd0;
      end else begin
         cnt_ok_q  <= cnt_ok_d;
         cnt_bad_q <= cnt_bad_d;
      end
   end

   assign rx_data       = rx_data_q;
   assign rx_valid      = rx_valid_q;
   assign rx_sof        = rx_sof_q;
   assign rx_eof        = rx_eof_q;
   assign rx_err        = rx_err_q;
   assign cnt_frame_ok  = cnt_ok_q;
   assign cnt_frame_bad = cnt_bad_q;

endmodule

// File: tb/tb_pcileech_eth_rmii_rx.sv
// tb/tb_pcileech_eth_rmii_rx.sv - self-checking bench for the RMII receive framer
`timescale 1ns/1ps
module tb_pcileech_eth_rmii_rx;

   localparam int MIN_F = 64;
   localparam int MAX_F = 1522;
`ifdef PCILEECH_ETH_RX_STRIP_FCS_EN
   localparam int STRIP = 4;
`else
   localparam int STRIP = 0;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        crs_dv = 1'b0;
   logic [1:0]  rxd = 2'b00;
   logic        rxer = 1'b0;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic        rx_sof;
   logic        rx_eof;
   logic        rx_err;
   logic [15:0] cnt_frame_ok;
   logic [15:0] cnt_frame_bad;

   always #10 clk = ~clk;

   pcileech_eth_rmii_rx #(
      .PARAM_MIN_FRAME(MIN_F),
      .PARAM_MAX_FRAME(MAX_F)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .eth_crs_dv   (crs_dv),
      .eth_rx_data  (rxd),
      .eth_rx_err   (rxer),
      .rx_data      (rx_data),
      .rx_valid     (rx_valid),
      .rx_sof       (rx_sof),
      .rx_eof       (rx_eof),
      .rx_err       (rx_err),
      .cnt_frame_ok (cnt_frame_ok),
      .cnt_frame_bad(cnt_frame_bad)
   );

   typedef struct {
      logic [7:0] data;
      logic       sof;
      logic       eof;
      logic       err;
   } cap_t;

   typedef struct {
      int plen;
      bit bad_fcs;
      int err_at;
      int toggle_at;
      int extra;
      int exp_out;
      int exp_err;
   } vec_t;

   cap_t       cap_q[$];
   logic [7:0] tx_q[$];
   int         n_checks = 0;
   int         n_errors = 0;
   int         exp_ok = 0;
   int         exp_bad = 0;

   always @(negedge clk) begin : mon
      cap_t c;
      if (rx_valid) begin
         c.data = rx_data;
         c.sof  = rx_sof;
         c.eof  = rx_eof;
         c.err  = rx_err;
         cap_q.push_back(c);
      end
   end

   initial begin : watchdog
      #2500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input int act, input int req);
      n_checks++;
      if (act != req) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, req);
      end
   endtask

   function automatic int sat16(input int v);
      return (v >= 65535) ? 65535 : v + 1;
   endfunction

   function automatic logic [31:0] crc_refl();
      logic [31:0] c;
      c = 32'hFFFFFFFF;
      foreach (tx_q[i]) begin
         c = c ^ {24'h0, tx_q[i]};
         for (int j = 0; j < 8; j++) begin
            c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
         end
      end
      return c;
   endfunction

   task automatic drv(input logic dv, input logic [1:0] d, input logic er);
      @(negedge clk);
      crs_dv = dv;
      rxd    = d;
      rxer   = er;
   endtask

   task automatic idle(input int n);
      repeat (n) drv(1'b0, 2'b00, 1'b0);
   endtask

   task automatic build_frame(input int plen, input bit bad_fcs, input bit rnd);
      logic [31:0] c;
      tx_q.delete();
      for (int i = 0; i < plen; i++) tx_q.push_back(rnd ? 8'($urandom) : 8'(i));
      c = ~crc_refl();
      for (int k = 0; k < 4; k++) tx_q.push_back(c[8*k +: 8]);
      if (bad_fcs) tx_q[plen] = tx_q[plen] ^ 8'hFF;
   endtask

   task automatic send_frame(input int err_at, input int toggle_at, input int extra, input int cut_at);
      logic [7:0] bv;
      idle(2);
      for (int i = 0; i < 31; i++) drv(1'b1, 2'b01, 1'b0);
      drv(1'b1, 2'b11, 1'b0);
      for (int b = 0; b < tx_q.size(); b++) begin
         if (b == cut_at) return;
         if (b == toggle_at) drv(1'b0, 2'b00, 1'b0);
         bv = tx_q[b];
         for (int k = 0; k < 4; k++) drv(1'b1, bv[2*k +: 2], (b == err_at) && (k == 0));
      end
      for (int k = 0; k < extra; k++) drv(1'b1, 2'b10, 1'b0);
      idle(6);
   endtask

   task automatic verify(input string tag, input int exp_out, input int exp_err);
      int mism;
      int sofbad;
      int eofbad;
      mism = 0;
      sofbad = 0;
      eofbad = 0;
      check({tag, " count"}, cap_q.size(), exp_out);
      for (int i = 0; i < cap_q.size(); i++) begin
         if (i >= tx_q.size() || cap_q[i].data != tx_q[i]) mism++;
         if (cap_q[i].sof != (i == 0)) sofbad++;
         if (cap_q[i].eof != (i == cap_q.size() - 1)) eofbad++;
      end
      check({tag, " data mismatches"}, mism, 0);
      check({tag, " sof misplaced"}, sofbad, 0);
      check({tag, " eof misplaced"}, eofbad, 0);
      if (exp_out > 0 && cap_q.size() > 0) check({tag, " err"}, int'(cap_q[cap_q.size()-1].err), exp_err);
      if (exp_out > 0 && exp_err == 0) exp_ok = sat16(exp_ok);
      else exp_bad = sat16(exp_bad);
      check({tag, " cnt_ok"}, cnt_frame_ok, exp_ok);
      check({tag, " cnt_bad"}, cnt_frame_bad, exp_bad);
      cap_q.delete();
   endtask

   initial begin : main
      vec_t tbl[11];
      logic [7:0] bv;
      int eofs;

      tbl[0]  = '{60,   1'b0, -1, -1, 0, 64 - STRIP,    0};
      tbl[1]  = '{60,   1'b1, -1, -1, 0, 64 - STRIP,    1};
      tbl[2]  = '{60,   1'b0, 20, 30, 0, 64 - STRIP,    1};
      tbl[3]  = '{96,   1'b0, -1, 50, 0, 100 - STRIP,   0};
      tbl[4]  = '{1596, 1'b0, -1, -1, 0, MAX_F - STRIP, 1};
      tbl[5]  = '{26,   1'b0, -1, -1, 0, 30 - STRIP,    1};
      tbl[6]  = '{59,   1'b0, -1, -1, 0, 63 - STRIP,    1};
      tbl[7]  = '{1518, 1'b0, -1, -1, 0, 1522 - STRIP,  0};
      tbl[8]  = '{1519, 1'b0, -1, -1, 0, MAX_F - STRIP, 1};
      tbl[9]  = '{60,   1'b0, -1, -1, 1, 64 - STRIP,    1};
      tbl[10] = '{1,    1'b0, -1, -1, 0, 5 - STRIP,     1};

      repeat (3) @(negedge clk);
      check("reset rx_valid", rx_valid, 0);
      check("reset sof/eof/err", {rx_sof, rx_eof, rx_err}, 0);
      check("reset rx_data", rx_data, 0);
      check("reset cnt_ok", cnt_frame_ok, 0);
      check("reset cnt_bad", cnt_frame_bad, 0);
      rst_n = 1'b1;
      idle(3);

      for (int t = 0; t < 11; t++) begin
         build_frame(tbl[t].plen, tbl[t].bad_fcs, 1'b0);
         send_frame(tbl[t].err_at, tbl[t].toggle_at, tbl[t].extra, -1);
         verify($sformatf("vec%0d", t), tbl[t].exp_out, tbl[t].exp_err);
      end

      // Preamble 55 55 5D.
      tx_q.delete();
      idle(2);
      for (int i = 0; i < 8; i++) drv(1'b1, 2'b01, 1'b0);
      bv = 8'h5D;
      for (int k = 0; k < 4; k++) drv(1'b1, bv[2*k +: 2], 1'b0);
      idle(6);
      verify("pre 5D", 0, 1);

      // Bad preamble dibit followed by frame-like junk: one bad count only.
      idle(2);
      drv(1'b1, 2'b01, 1'b0);
      drv(1'b1, 2'b01, 1'b0);
      drv(1'b1, 2'b00, 1'b0);
      for (int i = 0; i < 160; i++) drv(1'b1, 2'($urandom), 1'b0);
      idle(6);
      verify("pre bad dibit", 0, 1);

      // SFD then carrier drop.
      idle(2);
      for (int i = 0; i < 31; i++) drv(1'b1, 2'b01, 1'b0);
      drv(1'b1, 2'b11, 1'b0);
      idle(6);
      verify("sfd only", 0, 1);

      // False carrier: no counter change.
      idle(2);
      repeat (3) drv(1'b1, 2'b01, 1'b0);
      idle(6);
      check("false carrier count", cap_q.size(), 0);
      check("false carrier cnt_ok", cnt_frame_ok, exp_ok);
      check("false carrier cnt_bad", cnt_frame_bad, exp_bad);

      // Randomized frames against the reference model.
      for (int r = 0; r < 30; r++) begin
         int  plen;
         int  len;
         int  eo;
         int  ee;
         int  er_at;
         int  tg_at;
         bit  crc_ok;
         bit  odd;
         if ($urandom_range(0, 9) == 0) begin
            tx_q.delete();
         end else begin
            plen = $urandom_range(40, 120);
            build_frame(plen, $urandom_range(0, 3) == 0, 1'b1);
         end
         len    = tx_q.size();
         er_at  = (len > 0 && $urandom_range(0, 6) == 0) ? $urandom_range(0, len - 1) : -1;
         tg_at  = (len > 1 && $urandom_range(0, 2) == 0) ? $urandom_range(1, len - 1) : -1;
         odd    = (len > 0) && ($urandom_range(0, 9) == 0);
         crc_ok = (crc_refl() == 32'hDEBB20E3);
         if (len > MAX_F) begin
            eo = MAX_F - STRIP;
            ee = 1;
         end else if (len == 0 || len <= STRIP) begin
            eo = 0;
            ee = 1;
         end else begin
            eo = len - STRIP;
            ee = (!crc_ok || len < MIN_F || er_at >= 0 || odd) ? 1 : 0;
         end
         send_frame(er_at, tg_at, odd ? 1 : 0, -1);
         verify($sformatf("rnd%0d", r), eo, ee);
      end

      // Reset in the middle of a frame.
      build_frame(60, 1'b0, 1'b0);
      send_frame(-1, -1, 0, 30);
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      eofs = 0;
      foreach (cap_q[i]) if (cap_q[i].eof) eofs++;
      check("cut eof count", eofs, 0);
      check("cut reset rx_valid", rx_valid, 0);
      check("cut reset cnt_ok", cnt_frame_ok, 0);
      check("cut reset cnt_bad", cnt_frame_bad, 0);
      crs_dv = 1'b0;
      rxd    = 2'b00;
      rst_n  = 1'b1;
      cap_q.delete();
      exp_ok  = 0;
      exp_bad = 0;
      build_frame(60, 1'b0, 1'b0);
      send_frame(-1, -1, 0, -1);
      verify("after reset", 64 - STRIP, 0);

      // Counter saturation.
      idle(2);
      force dut.cnt_ok_q = 16'hFFFE;
      idle(2);
      release dut.cnt_ok_q;
      idle(2);
      exp_ok = 16'hFFFE;
      check("sat preload", cnt_frame_ok, exp_ok);
      for (int s = 0; s < 3; s++) begin
         build_frame(60, 1'b0, 1'b1);
         send_frame(-1, -1, 0, -1);
         verify($sformatf("sat%0d", s), 64 - STRIP, 0);
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
